apb_master_arb: RTL



---
 rtl/apb_master_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apb_master_arb.sv
// Shared APB master: round-robin arbitration among internal requesters, then
// SETUP/ACCESS sequencing with wait states, slave error and bus timeout.
module apb_master_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVE_NUM  = 8,
  parameter int SEL_LSB    = 12,
  parameter int REQ_NUM    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                            pclk,
  input  logic                            preset_n,
  input  logic [REQ_NUM-1:0]              req_valid,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]   req_addr,
  input  logic [REQ_NUM-1:0]              req_write,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]   req_wdata,
  input  logic [REQ_NUM*DATA_WIDTH/8-1:0] req_strb,
  input  logic [REQ_NUM*3-1:0]            req_prot,
  output logic [REQ_NUM-1:0]              req_ready,
  output logic [REQ_NUM-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic                            timeout,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]           pwdata,
  output logic                            pwrite,
  output logic                            penable,
  output logic [DATA_WIDTH/8-1:0]         pstrb,
  output logic [2:0]                      pprot,
  output logic [SLAVE_NUM-1:0]            psel,
  input  logic [DATA_WIDTH-1:0]           prdata,
  input  logic                            pready,
  input  logic                            pslverr
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = $clog2(SLAVE_NUM);
  localparam int GNT_W  = $clog2(REQ_NUM);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state_reg;
  logic [GNT_W-1:0]   last_grant_reg;
  logic [GNT_W-1:0]   owner_reg;
  logic [7:0]         wait_cnt_reg;
  logic [GNT_W-1:0]   winner;
  logic [GNT_W-1:0]   cand;
  logic               grant_found;
  logic               grant;
  logic               tmo_hit;
  logic               xfer_done;
  logic               arb_point;

  logic [ADDR_WIDTH-1:0] addr_arr  [REQ_NUM];
  logic [DATA_WIDTH-1:0] wdata_arr [REQ_NUM];
  logic [STRB_W-1:0]     strb_arr  [REQ_NUM];
  logic [2:0]            prot_arr  [REQ_NUM];

  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
      assign prot_arr[gi]  = req_prot[gi*3 +: 3];
    end
  endgenerate

  // pready in the same cycle as the timeout limit takes priority.
  assign tmo_hit   = (state_reg == ACCESS) && !pready && (wait_cnt_reg == 8'(TIMEOUT - 1));
  assign xfer_done = (state_reg == ACCESS) && (pready || tmo_hit);
  assign arb_point = (state_reg == IDLE) || xfer_done;

  always_comb begin
    winner      = '0;
    cand        = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = GNT_W'((int'(last_grant_reg) + k) % REQ_NUM);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        winner      = cand;
      end
    end
  end

  assign grant     = preset_n && arb_point && grant_found;
  assign req_ready = grant ? (REQ_NUM'(1) << winner) : '0;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_W'(REQ_NUM - 1);
      owner_reg      <= '0;
      wait_cnt_reg   <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      timeout        <= 1'b0;
      paddr          <= '0;
      pwdata         <= '0;
      pwrite         <= 1'b0;
      penable        <= 1'b0;
      pstrb          <= '0;
      pprot          <= '0;
      psel           <= '0;
    end else begin
      rsp_valid <= '0;
      timeout   <= 1'b0;

      case (state_reg)
        SETUP: begin
          penable      <= 1'b1;
          wait_cnt_reg <= '0;
          state_reg    <= ACCESS;
        end
        ACCESS: begin
          if (!xfer_done)
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
        default: ;
      endcase

      if (xfer_done) begin
        rsp_valid <= REQ_NUM'(1) << owner_reg;
        rsp_err   <= pready ? pslverr : 1'b1;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        timeout   <= tmo_hit;
      end

      // A grant overrides the return to IDLE so transfers run back-to-back.
      if (grant) begin
        state_reg      <= SETUP;
        owner_reg      <= winner;
        last_grant_reg <= winner;
        paddr          <= addr_arr[winner];
        pwrite         <= req_write[winner];
        pwdata         <= req_write[winner] ? wdata_arr[winner] : '0;
        pstrb          <= req_write[winner] ? strb_arr[winner] : '0;
        pprot          <= prot_arr[winner];
        psel           <= SLAVE_NUM'(1) << addr_arr[winner][SEL_LSB +: SEL_W];
        penable        <= 1'b0;
      end else if (xfer_done) begin
        state_reg <= IDLE;
        psel      <= '0;
        penable   <= 1'b0;
      end
    end
  end
endmodule
